timer_scheduler: RTL and testbench

Multi-channel millisecond timer scheduler built around a shared prescaler. One free-running tick generator divides the system clock to a 1 ms tick. N_CH independent channels count down programmable periods against that tick. Expirations are queued as pending flags and handed to the consumer one at a time through a round-robin valid/ready port. It sits between the control/register logic and any block that needs periodic or one-shot timeouts.

---
 rtl/timer_sched_pkg.sv | 20 ++
 rtl/tick_prescaler.sv | 46 ++++
 rtl/timer_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_timer_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_sched_pkg.sv
// ============================================================================
// Module  : timer_sched_pkg
// Brief   : Shared types and default constants for timer_scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_sched_pkg;

    localparam int CLK_PER_TICK_1MS = 100000;
    localparam int PW_DEFAULT       = 10;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module  : tick_prescaler
// Brief   : Free-running clock divider producing a registered one-cycle tick.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler
    import timer_sched_pkg::*;
#(
    parameter int CLK_PER_TICK = CLK_PER_TICK_1MS
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int            CW     = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(CLK_PER_TICK - 1);

    logic [CW-1:0] r_pcount;
    logic          r_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcount <= '0;
            r_tick   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (i_en) begin
                if (r_pcount == C_LAST) begin
                    r_pcount <= '0;
                    r_tick   <= 1'b1;
                end else begin
                    r_pcount <= r_pcount + CW'(1);
                end
            end
        end
    end

    assign o_tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/timer_scheduler.sv
// ============================================================================
// Module  : timer_scheduler
// Brief   : N-channel tick-based timer array with round-robin expiry handoff.
//           TIMER_SCHED_RELOAD_EN selects periodic channels (else one-shot).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_scheduler
    import timer_sched_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int CLK_PER_TICK = CLK_PER_TICK_1MS,
    parameter int PW           = PW_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic                    i_cfg_we,
    input  logic [$clog2(N_CH)-1:0] i_cfg_ch,
    input  logic                    i_cfg_arm,
    input  logic [PW-1:0]           i_cfg_period,
    output logic                    o_tick,
    output logic [N_CH-1:0]         o_active,
    output logic [N_CH-1:0]         o_overflow,
    output logic                    o_expire_valid,
    output logic [$clog2(N_CH)-1:0] o_expire_ch,
    input  logic                    i_expire_ready
);

    localparam int CW = $clog2(N_CH);

    logic            w_tick;
    logic            w_tick_en;
    logic            w_arm;
    logic [N_CH-1:0] w_pending;
    logic [N_CH-1:0] w_clr;
    logic            w_found;
    logic [CW-1:0]   w_sel;

    arb_state_e      r_state;
    logic            r_valid;
    logic [CW-1:0]   r_ch;
    logic [CW-1:0]   r_rr_ptr;

    tick_prescaler #(
        .CLK_PER_TICK (CLK_PER_TICK)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_en   (i_en),
        .o_tick (w_tick)
    );

    assign w_tick_en = w_tick & i_en;
    // A zero period arms nothing, so it collapses into a disarm.
    assign w_arm     = i_cfg_arm && (i_cfg_period != '0);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic          w_wr;
        logic          w_dec;
        logic          w_exp;
        logic          r_act;
        logic          r_pend;
        logic          r_ovf;
        logic [PW-1:0] r_rem;

        assign w_wr  = i_cfg_we && (i_cfg_ch == CW'(gi));
        assign w_dec = w_tick_en && r_act && !w_wr;
        assign w_exp = w_dec && (r_rem == PW'(1));

`ifdef TIMER_SCHED_RELOAD_EN
        logic [PW-1:0] r_reload;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_reload <= '0;
            end else if (w_wr && w_arm) begin
                r_reload <= i_cfg_period;
            end
        end
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_act  <= 1'b0;
                r_rem  <= '0;
                r_ovf  <= 1'b0;
                r_pend <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_act <= w_arm;
                    r_rem <= w_arm ? i_cfg_period : '0;
                    r_ovf <= 1'b0;
                end else if (w_exp) begin
`ifdef TIMER_SCHED_RELOAD_EN
                    r_rem <= r_reload;
`else
                    r_act <= 1'b0;
                    r_rem <= '0;
`endif
                    if (r_pend) begin
                        r_ovf <= 1'b1;
                    end
                end else if (w_dec) begin
                    r_rem <= r_rem - PW'(1);
                end

                // A fresh expiry outranks the handshake clear of the same bit.
                if (w_exp) begin
                    r_pend <= 1'b1;
                end else if (w_clr[gi]) begin
                    r_pend <= 1'b0;
                end
            end
        end

        assign o_active[gi]   = r_act;
        assign o_overflow[gi] = r_ovf;
        assign w_pending[gi]  = r_pend;
    end

    function automatic logic [CW-1:0] f_wrap(input int v);
        f_wrap = (v >= N_CH) ? CW'(v - N_CH) : CW'(v);
    endfunction

    // Descending scan so the lowest offset from the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (w_pending[f_wrap(int'(r_rr_ptr) + k)]) begin
                w_found = 1'b1;
                w_sel   = f_wrap(int'(r_rr_ptr) + k);
            end
        end
    end

    always_comb begin
        w_clr = '0;
        if ((r_state == ST_PRESENT) && i_expire_ready) begin
            w_clr[r_ch] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_valid  <= 1'b0;
            r_ch     <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_ch    <= w_sel;
                        r_valid <= 1'b1;
                        r_state <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (i_expire_ready) begin
                        r_valid  <= 1'b0;
                        r_rr_ptr <= (r_ch == CW'(N_CH - 1)) ? '0 : r_ch + CW'(1);
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tick         = w_tick;
    assign o_expire_valid = r_valid;
    assign o_expire_ch    = r_ch;

endmodule

`default_nettype wire

// File: tb/tb_timer_scheduler.sv
// ============================================================================
// Module  : tb_timer_scheduler
// Brief   : Scoreboard bench for timer_scheduler (CLK_PER_TICK=10).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_scheduler;

    localparam int N_CH = 4;
    localparam int CPT  = 10;
    localparam int PW   = 10;
`ifdef TIMER_SCHED_RELOAD_EN
    localparam int RELOAD = 1;
`else
    localparam int RELOAD = 0;
`endif

    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_ch = '0;
    logic          cfg_arm = 1'b0;
    logic [PW-1:0] cfg_period = '0;
    logic          tick;
    logic [N_CH-1:0] active;
    logic [N_CH-1:0] overflow;
    logic          expire_valid;
    logic [1:0]    expire_ch;
    logic          expire_ready = 1'b1;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q[$];

    timer_scheduler #(
        .N_CH         (N_CH),
        .CLK_PER_TICK (CPT),
        .PW           (PW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_en           (en),
        .i_cfg_we       (cfg_we),
        .i_cfg_ch       (cfg_ch),
        .i_cfg_arm      (cfg_arm),
        .i_cfg_period   (cfg_period),
        .o_tick         (tick),
        .o_active       (active),
        .o_overflow     (overflow),
        .o_expire_valid (expire_valid),
        .o_expire_ch    (expire_ch),
        .i_expire_ready (expire_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: sampled mid-low-phase so the cycle's inputs are settled.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (q.size() == 0) begin
                chk("spurious_valid", int'(expire_valid), 0);
            end else if (expire_valid) begin
                chk("expire_ch", int'(expire_ch), q[0].ch);
                if (expire_ready) begin
                    chk("grant_cycle", cyc, q[0].cyc);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic push(input int ch, input int c);
        exp_t e;
        e.ch  = ch;
        e.cyc = c;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic cfg(input int ch, input logic arm, input int period);
        cfg_we     = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_arm    = arm;
        cfg_period = PW'(period);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        rst          = 1'b1;
        cfg_we       = 1'b0;
        expire_ready = rdy;
        q.delete();
        repeat (3) @(negedge clk);
        chk("rst_tick", int'(tick), 0);
        chk("rst_valid", int'(expire_valid), 0);
        chk("rst_ch", int'(expire_ch), 0);
        chk("rst_active", int'(active), 0);
        chk("rst_overflow", int'(overflow), 0);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic drain(input string name);
        chk(name, q.size(), 0);
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;

        // Single channel, period 3: ticks at 10/20/30 -> grant at 32.
        do_reset(1'b1);
        wait_cyc(2);
        push(1, 32);
`ifdef TIMER_SCHED_RELOAD_EN
        push(1, 62);
`endif
        cfg(1, 1'b1, 3);
        chk("s1_active_after_arm", int'(active[1]), 1);
        wait_cyc(70);
        chk("s1_active_end", int'(active[1]), RELOAD);
        chk("s1_overflow", int'(overflow), 0);
        drain("s1_drain");

        // Four channels, period 2, expire together on tick 20.
        do_reset(1'b1);
        wait_cyc(2);
        push(0, 22); push(1, 24); push(2, 26); push(3, 28);
`ifdef TIMER_SCHED_RELOAD_EN
        push(0, 42); push(1, 44); push(2, 46); push(3, 48);
`endif
        for (int i = 0; i < 4; i++) cfg(i, 1'b1, 2);
        chk("s2_active", int'(active), 15);
        wait_cyc(50);
        chk("s2_overflow", int'(overflow), 0);
        drain("s2_drain");

        // Backpressure: ch2 period 1 held unconsumed until cycle 37.
        do_reset(1'b0);
        wait_cyc(2);
        push(2, 37);
`ifdef TIMER_SCHED_RELOAD_EN
        push(2, 42);
`endif
        cfg(2, 1'b1, 1);
        wait_cyc(15);
        chk("s3_valid_held", int'(expire_valid), 1);
        chk("s3_overflow_early", int'(overflow[2]), 0);
        wait_cyc(22);
        chk("s3_overflow_late", int'(overflow[2]), RELOAD);
        wait_cyc(37);
        expire_ready = 1'b1;
        wait_cyc(45);
        drain("s3_drain");

        // Zero period with arm=1 behaves as disarm.
        do_reset(1'b1);
        wait_cyc(2);
        cfg(0, 1'b1, 0);
        chk("s4_active", int'(active[0]), 0);
        wait_cyc(45);
        chk("s4_active_end", int'(active), 0);
        drain("s4_drain");

        // Config write to ch1 coincident with tick 20; ch0 still decrements.
        do_reset(1'b1);
        wait_cyc(2);
        push(0, 52);
        push(1, 62);
        cfg(0, 1'b1, 5);
        cfg(1, 1'b1, 7);
        wait_cyc(20);
        chk("s5_tick_cycle", int'(tick), 1);
        cfg(1, 1'b1, 4);
        chk("s5_ch1_remain", int'(dut.g_ch[1].r_rem), 4);
        chk("s5_ch0_remain", int'(dut.g_ch[0].r_rem), 3);
        wait_cyc(70);
        drain("s5_drain");

        // Asynchronous reset while an expiration is being presented.
        do_reset(1'b0);
        wait_cyc(2);
        push(1, 0);
        cfg(1, 1'b1, 1);
        wait_cyc(13);
        chk("s6_valid_before", int'(expire_valid), 1);
        rst = 1'b1;
        #1;
        chk("s6_valid_rst", int'(expire_valid), 0);
        chk("s6_active_rst", int'(active), 0);
        chk("s6_pending_rst", int'(dut.w_pending), 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        t = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tick && t < 0) t = cyc;
        end
        chk("s6_first_tick", t, 10);
        drain("s6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
